mult_div_unit: RTL and testbench

Multi-cycle signed multiply/divide unit for the multicycle MIPS datapath. It sits directly upstream of the HI/LO select muxes and the HI and LO registers. It takes operands from the A and B register outputs, runs a 32-iteration shift-add multiply or restoring divide, and presents a 64-bit result as `hi`/`lo`. The control FSM starts an operation with a one-cycle pulse and waits for `done` before asserting WriteHI/WriteLO.

---
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/mult_div_unit.sv | 152 +++++++++++++++
 tb/tb_mult_div_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the multicycle datapath control and the
// multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             mult_start;
    logic             div_start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output mult_start, div_start, op_a, op_b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  mult_start, div_start, op_a, op_b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Signed 32-iteration shift-add multiplier and restoring divider feeding the
// MIPS HI/LO registers; one result bit per clock, sign fix-up on the last edge.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  iter;
    logic [WIDTH:0]    work_hi;
    logic [WIDTH-1:0]  work_lo;
    logic [WIDTH-1:0]  addend;
    logic              res_neg;
    logic              dvd_neg;

    function automatic logic signed [WIDTH-1:0] apply_sign(
        input logic signed [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic signed [2*WIDTH-1:0] apply_sign_wide(
        input logic signed [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return apply_sign(v, v[WIDTH-1]);
    endfunction

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    can_start;
    logic                    take_mult;
    logic                    take_div;

    assign a_s       = bus.op_a;
    assign b_s       = bus.op_b;
    assign can_start = (state == IDLE) || (state == DONE);
    assign take_mult = can_start && bus.mult_start;
    assign take_div  = can_start && bus.div_start && !bus.mult_start;

    logic [WIDTH-1:0] addend_sel;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    // Multiply: add into the upper half, then shift {carry, hi, lo} right.
    // Divide: shift the next dividend bit into the remainder and try a subtract.
    always_comb begin
        addend_sel = work_lo[0] ? addend : '0;
        sum        = {1'b0, work_hi[WIDTH-1:0]} + {1'b0, addend_sel};
        shifted    = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
        trial      = {1'b0, shifted} - {2'b00, addend};
        nxt_hi     = work_hi;
        nxt_lo     = work_lo;
        if (state == MULT) begin
            nxt_hi = {1'b0, sum[WIDTH:1]};
            nxt_lo = {sum[0], work_lo[WIDTH-1:1]};
        end else if (trial[WIDTH+1]) begin
            nxt_hi = shifted;
            nxt_lo = {work_lo[WIDTH-2:0], 1'b0};
        end else begin
            nxt_hi = trial[WIDTH:0];
            nxt_lo = {work_lo[WIDTH-2:0], 1'b1};
        end
    end

    logic signed [2*WIDTH-1:0] prod_s;
    logic signed [WIDTH-1:0]   quo_s;
    logic signed [WIDTH-1:0]   rem_s;

    assign prod_s = apply_sign_wide({nxt_hi[WIDTH-1:0], nxt_lo}, res_neg);
    assign quo_s  = apply_sign(nxt_lo, res_neg);
    assign rem_s  = apply_sign(nxt_hi[WIDTH-1:0], dvd_neg);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            iter         <= '0;
            work_hi      <= '0;
            work_lo      <= '0;
            addend       <= '0;
            res_neg      <= 1'b0;
            dvd_neg      <= 1'b0;
            bus.hi       <= '0;
            bus.lo       <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
        end else begin
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    iter     <= '0;
                    if (take_mult) begin
                        state    <= MULT;
                        bus.busy <= 1'b1;
                        addend   <= magnitude(a_s);
                        work_lo  <= magnitude(b_s);
                        work_hi  <= '0;
                        res_neg  <= a_s[WIDTH-1] ^ b_s[WIDTH-1];
                        dvd_neg  <= a_s[WIDTH-1];
                    end else if (take_div) begin
                        if (bus.op_b == '0) begin
                            // Zero divisor: flag it and leave HI/LO untouched.
                            state        <= DONE;
                            bus.done     <= 1'b1;
                            bus.div_zero <= 1'b1;
                        end else begin
                            state    <= DIV;
                            bus.busy <= 1'b1;
                            addend   <= magnitude(b_s);
                            work_lo  <= magnitude(a_s);
                            work_hi  <= '0;
                            res_neg  <= a_s[WIDTH-1] ^ b_s[WIDTH-1];
                            dvd_neg  <= a_s[WIDTH-1];
                        end
                    end
                end
                MULT, DIV: begin
                    work_hi <= nxt_hi;
                    work_lo <= nxt_lo;
                    iter    <= iter + CNT_W'(1);
                    if (iter == LAST_ITER) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        if (state == MULT) begin
                            {bus.hi, bus.lo} <= prod_s;
                        end else begin
                            bus.hi <= rem_s;
                            bus.lo <= quo_s;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mult_div_unit_if #(.WIDTH(32)) bus();
    mult_div_unit #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_hi      = '0;
    logic [31:0] exp_lo      = '0;
    logic        exp_dz      = 1'b0;
    int          exp_busy    = 0;
    int          exp_cyc     = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        vectors++;
        if (obs !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Called at a falling edge; the request is held across one rising edge.
    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        bus.mult_start = m;
        bus.div_start  = d;
        bus.op_a       = a;
        bus.op_b       = b;
        if (m) begin
            r = sa * sb;
            exp_hi = r[63:32]; exp_lo = r[31:0];
            exp_dz = 1'b0; exp_busy = 32; exp_cyc = 33;
        end else if (b == 32'd0) begin
            exp_dz = 1'b1; exp_busy = 0; exp_cyc = 1;
        end else begin
            r = sa / sb; exp_lo = r[31:0];
            r = sa % sb; exp_hi = r[31:0];
            exp_dz = 1'b0; exp_busy = 32; exp_cyc = 33;
        end
        @(posedge clock);
        #1;
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.op_a       = $urandom;
        bus.op_b       = $urandom;
    endtask

    // Returns at the falling edge where done is seen (or after the bound).
    task automatic wait_done(input string tag, input bit glitch);
        int busyc = 0;
        int cyc   = 0;
        bit seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            cyc++;
            if (bus.done) seen = 1'b1;
            else begin
                if (bus.busy) busyc++;
                bus.op_a       = $urandom;
                bus.op_b       = $urandom;
                bus.mult_start = glitch && (busyc == 10);
            end
        end
        bus.mult_start = 1'b0;
        check({tag, "_done"}, seen, 1);
        check({tag, "_busy_cycles"}, busyc, exp_busy);
        check({tag, "_latency"}, cyc, exp_cyc);
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
        check({tag, "_div_zero"}, bus.div_zero, exp_dz);
    endtask

    task automatic settle(input string tag);
        @(negedge clock);
        check({tag, "_done_drop"}, bus.done, 0);
        check({tag, "_dz_drop"}, bus.div_zero, 0);
        check({tag, "_idle_busy"}, bus.busy, 0);
        check({tag, "_hold_hi"}, bus.hi, exp_hi);
        check({tag, "_hold_lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end

    initial begin
        int dones;
        bit m;
        reset          = 1'b0;
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        repeat (3) @(negedge clock);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dz", bus.div_zero, 0);
        reset = 1'b1;
        @(negedge clock);

        start_op(1, 0, 32'd7, 32'hFFFF_FFFD);
        wait_done("mul_mixed", 0);
        check("mul_mixed_hi_const", bus.hi, 32'hFFFF_FFFF);
        check("mul_mixed_lo_const", bus.lo, 32'hFFFF_FFEB);
        settle("mul_mixed");

        start_op(1, 0, 32'h8000_0000, 32'h8000_0000);
        wait_done("mul_extreme", 0);
        check("mul_extreme_hi_const", bus.hi, 32'h4000_0000);
        check("mul_extreme_lo_const", bus.lo, 32'h0000_0000);
        settle("mul_extreme");

        start_op(0, 1, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 0);
        check("div_neg_lo_const", bus.lo, 32'hFFFF_FFFD);
        check("div_neg_hi_const", bus.hi, 32'hFFFF_FFFF);
        settle("div_neg");

        start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 0);
        check("div_ovf_lo_const", bus.lo, 32'h8000_0000);
        check("div_ovf_hi_const", bus.hi, 32'h0000_0000);
        settle("div_ovf");

        start_op(0, 1, 32'h5678_1234, 32'h0001_0000);
        wait_done("div_prep", 0);
        settle("div_prep");
        start_op(0, 1, 32'h1111_1111, 32'd0);
        wait_done("div_zero", 0);
        check("div_zero_hi_const", bus.hi, 32'h0000_1234);
        check("div_zero_lo_const", bus.lo, 32'h0000_5678);
        settle("div_zero");

        start_op(0, 1, $urandom, 32'h0000_0013);
        wait_done("div_glitch", 1);
        settle("div_glitch");

        start_op(1, 1, 32'hFFFF_F000, 32'h0123_4567);
        wait_done("both_start", 0);
        settle("both_start");

        start_op(1, 0, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_done("b2b_first", 0);
        start_op(0, 1, 32'h7FFF_FFFF, 32'hFFFF_FFF0);
        wait_done("b2b_second", 0);
        start_op(0, 1, 32'h0000_0005, 32'd0);
        wait_done("b2b_divzero", 0);
        settle("b2b_divzero");

        start_op(1, 0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        repeat (10) @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_dz", bus.div_zero, 0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clock);
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.done || bus.busy) dones++;
        end
        check("abort_no_activity", dones, 0);
        check("abort_after_hi", bus.hi, 0);

        for (int n = 0; n < 40; n++) begin
            m = $urandom_range(0, 1) == 1;
            start_op(m, !m, pick_operand(), pick_operand());
            wait_done($sformatf("rnd%0d", n), $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0) settle($sformatf("rnd%0d", n));
        end
        settle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
